// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard / stall / flush controller for a 5-stage in-order pipe.
//
// Watches the ID, EX and MEM stages and decides each cycle whether to stall,
// bubble or flush the pipe, and whether to redirect the PC. All control
// outputs are Mealy (combinational from state and inputs), so a hazard is
// acted on in the cycle it is seen. Only state_o is a register.
//
// Optional feature: define PIPELINE_CTRL_PERF_EN to add saturating
// performance counters stall_cnt_o / flush_cnt_o.
//
// Parameters
//   MEM_TIMEOUT   max MEM_WAIT cycles before a data access is abandoned (2..255)
//   FLUSH_CYCLES  cycles flush_o stays high per redirect (1..7)
//   CNT_W         performance counter width
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   id_rs1/rs2_addr_i, *_used_i   ID-stage source operands
//   ex_rd_addr_i, ex_reg_wr_sig_i, ex_is_load_i   EX-stage destination info
//   mem_br_taken_i, mem_new_pc_i  MEM-stage redirect request and target
//   mem_access_i, dmem_ready_i    MEM-stage data access handshake
//   stall_{if,id,ex,mem}_o        hold PC / IF-ID / ID-EX / EX-MEM
//   bubble_ex_o                   insert NOP into ID/EX
//   flush_o                       clear IF/ID, ID/EX, EX/MEM
//   pc_load_o, pc_target_o        PC redirect (target 0 when not loading)
//   dmem_timeout_o                one-cycle pulse when an access is abandoned
//   state_o                       RUN=0 LOAD_USE=1 MEM_WAIT=2 REDIRECT=3
//   stall_cnt_o, flush_cnt_o      (PERF_EN only) stall cycles / redirect events
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_reg_wr_sig_i,
  input  logic             ex_is_load_i,
  input  logic             mem_br_taken_i,
  input  logic [31:0]      mem_new_pc_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             bubble_ex_o,
  output logic             flush_o,
  output logic             pc_load_o,
  output logic [31:0]      pc_target_o,
  output logic             dmem_timeout_o,
  output logic [1:0]       state_o
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [7:0] MT_L = 8'(MEM_TIMEOUT);
  localparam logic [3:0] FC_L = 4'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;   // MEM_WAIT cycle index, 1 on first wait cycle
  logic [2:0]  fcnt_q, fcnt_d;   // flush cycles already issued for this redirect
  logic [31:0] tgt_q, tgt_d;     // captured redirect target

  logic mem_wait, load_use;
  logic stall_fe_c, stall_be_c, bubble_c, flush_c, pc_load_c, tmo_c;

  assign mem_wait = mem_access_i & ~dmem_ready_i;
  assign load_use = ex_is_load_i & ex_reg_wr_sig_i & (ex_rd_addr_i != 5'd0) &
                    ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                     (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

  // Decision logic. stall_fe covers IF/ID, stall_be covers EX/MEM; load-use
  // only holds the front end and bubbles EX, a memory wait freezes everything.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    fcnt_d     = fcnt_q;
    tgt_d      = tgt_q;
    stall_fe_c = 1'b0;
    stall_be_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    pc_load_c  = 1'b0;
    tmo_c      = 1'b0;
    case (state_q)
      RUN, LOAD_USE: begin
        if (mem_wait) begin
          stall_fe_c = 1'b1;
          stall_be_c = 1'b1;
          wcnt_d     = 8'd1;
          state_d    = MEM_WAIT;
        end else if (mem_br_taken_i) begin
          pc_load_c = 1'b1;
          flush_c   = 1'b1;
          tgt_d     = mem_new_pc_i;
          fcnt_d    = 3'd1;
          state_d   = (FLUSH_CYCLES == 1) ? RUN : REDIRECT;
        end else if (load_use && state_q == RUN) begin
          // The instruction after a load-use stall re-presents the same
          // operands; by then the load has moved on, so don't stall twice.
          stall_fe_c = 1'b1;
          bubble_c   = 1'b1;
          state_d    = LOAD_USE;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d = RUN;
        end else if (wcnt_q == MT_L) begin
          tmo_c   = 1'b1;
          state_d = RUN;
        end else begin
          stall_fe_c = 1'b1;
          stall_be_c = 1'b1;
          wcnt_d     = wcnt_q + 8'd1;
        end
      end
      REDIRECT: begin
        flush_c = 1'b1;
        if (({1'b0, fcnt_q} + 4'd1) >= FC_L) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q + 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Outputs are gated by reset_n so asserting reset silences them at once,
  // even though they are combinational from live inputs.
  assign stall_if_o     = reset_n & stall_fe_c;
  assign stall_id_o     = reset_n & stall_fe_c;
  assign stall_ex_o     = reset_n & stall_be_c;
  assign stall_mem_o    = reset_n & stall_be_c;
  assign bubble_ex_o    = reset_n & bubble_c;
  assign flush_o        = reset_n & flush_c;
  assign pc_load_o      = reset_n & pc_load_c;
  assign pc_target_o    = pc_load_o ? mem_new_pc_i : 32'd0;
  assign dmem_timeout_o = reset_n & tmo_c;
  assign state_o        = state_q;

  // The captured target must match what was presented on the redirect cycle.
  a_tgt_capture: assert property (@(posedge clk) disable iff (!reset_n)
    pc_load_o |=> (tgt_q == $past(mem_new_pc_i)));

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_if_o && stall_cnt_o != {CNT_W{1'b1}})
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (pc_load_o && flush_cnt_o != {CNT_W{1'b1}})
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles before the data-memory access is abandoned; legal range 2..255.
REQ-002 Parameter FLUSH_CYCLES, default 2: number of cycles flush_o stays asserted per redirect; legal range 1..7.
REQ-003 Parameter CNT_W, default 32: width of the performance counters.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 id_rs1_addr_i / id_rs2_addr_i  in  5 each  ID-stage source register addresses.
REQ-007 id_rs1_used_i / id_rs2_used_i  in  1 each  ID-stage instruction reads rs1 / rs2.
REQ-008 ex_rd_addr_i  in  5  EX-stage destination register.
REQ-009 ex_reg_wr_sig_i  in  1  EX-stage instruction writes the register file.
REQ-010 ex_is_load_i  in  1  EX-stage instruction is a load.
REQ-011 mem_br_taken_i  in  1  MEM-stage branch/jump taken (EX/MEM br_taken).
REQ-012 mem_new_pc_i  in  32  MEM-stage redirect target (EX/MEM new_pc).
REQ-013 mem_access_i  in  1  MEM-stage instruction performs a load or store.
REQ-014 dmem_ready_i  in  1  data memory completes the access this cycle.
REQ-015 stall_if_o / stall_id_o / stall_ex_o / stall_mem_o  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers.
REQ-016 bubble_ex_o  out  1  load ID/EX with a NOP (all write enables 0).
REQ-017 flush_o  out  1  clear IF/ID, ID/EX and EX/MEM to reset values.
REQ-018 pc_load_o  out  1  load PC from pc_target_o.
REQ-019 pc_target_o  out  32  redirect target.
REQ-020 dmem_timeout_o  out  1  one-cycle pulse: access abandoned.
REQ-021 state_o  out  2  current state: RUN=0, LOAD_USE=1, MEM_WAIT=2, REDIRECT=3.

Function
REQ-022 All outputs except state_o shall be combinational (Mealy) from state and inputs, so a hazard is acted on in the same cycle it is detected.
REQ-023 Load-use hazard = ex_is_load_i & ex_reg_wr_sig_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
REQ-024 Priority in RUN: memory wait (mem_access_i & !dmem_ready_i) > redirect (mem_br_taken_i) > load-use hazard.
REQ-025 RUN, memory wait: assert all four stall_*_o; next state MEM_WAIT; wait counter <= 1.
REQ-026 MEM_WAIT: if dmem_ready_i, no stall asserted and next state RUN; otherwise all stalls asserted and wait counter increments.
REQ-027 MEM_WAIT with wait counter == MEM_TIMEOUT and dmem_ready_i low: stalls released, dmem_timeout_o=1 for that cycle, next state RUN.
REQ-028 mem_br_taken_i and load-use detection shall be ignored in MEM_WAIT.
REQ-029 RUN, redirect: pc_load_o=1, pc_target_o=mem_new_pc_i, flush_o=1 in the same cycle; the target is captured; flush counter <= 1; next state REDIRECT (or RUN if FLUSH_CYCLES==1).
REQ-030 REDIRECT: flush_o=1, pc_load_o=0, no stalls; mem_access_i, mem_br_taken_i and load-use ignored; return to RUN after FLUSH_CYCLES total flush cycles.
REQ-031 RUN, load-use only: stall_if_o=stall_id_o=bubble_ex_o=1 for exactly one cycle; next state LOAD_USE.
REQ-032 LOAD_USE: behaves as RUN except that load-use detection is suppressed; next state RUN unless a memory wait or redirect occurs, which follows REQ-025/REQ-029.
REQ-033 pc_target_o shall be 0 whenever pc_load_o=0.

Reset
REQ-034 reset_n low shall immediately force the state to RUN, clear all counters and the captured target, and drive every output to 0, including mid-MEM_WAIT or mid-REDIRECT.
REQ-035 The first rising edge after reset_n deasserts shall evaluate inputs as in RUN.

Configuration
REQ-036 Macro PIPELINE_CTRL_PERF_EN defined: add outputs stall_cnt_o (CNT_W) and flush_cnt_o (CNT_W), both reset to 0 and saturating at all-ones.
REQ-037 stall_cnt_o shall count cycles with stall_if_o=1; flush_cnt_o shall count redirect events (REQ-029).
REQ-038 Macro undefined: these ports and counters shall be absent; all other behaviour shall be identical.

Verification
REQ-039 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, rs1_used=1 -> stall_if/stall_id/bubble_ex high for 1 cycle, state 1 then 0.
REQ-040 Mem wait: mem_access=1, dmem_ready low for 3 cycles, then high -> all stalls high for 3 cycles, released in the ready cycle, state 2 -> 0.
REQ-041 Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> dmem_timeout_o pulses on the 4th MEM_WAIT cycle, stalls released, state 0.
REQ-042 Redirect: mem_br_taken=1, new_pc=0x0000_0100, simultaneous load-use -> pc_load=1, pc_target=0x100, bubble_ex=0, flush_o high for 2 cycles.
REQ-043 Reset mid-MEM_WAIT: reset_n low during the 2nd wait cycle -> all outputs 0 immediately, state 0.
REQ-044 With PIPELINE_CTRL_PERF_EN: REQ-040 followed by REQ-042 -> stall_cnt_o=3, flush_cnt_o=1.
